// File: rtl/mul_div_seq.sv
// rtl/mul_div_seq.sv - iterative signed multiplier/divider; divider built only with MULDIV_DIV_EN
module mul_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_mul,
  input  logic             op_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [2*WIDTH-1:0] prod_fixed;

`ifdef MULDIV_DIV_EN
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH:0]     div_rem_sh;
  logic [WIDTH:0]     div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] div_step;
  logic [WIDTH-1:0]   quo_fixed, rem_fixed;
`endif

  assign busy        = (state_q == S_PREP) || (state_q == S_RUN) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign result_hi   = hi_q;
  assign result_lo   = lo_q;
  assign div_by_zero = dbz_q;

  // Datapath helpers: operand magnitudes, one shift-add step, one restoring step, sign fix-up
  always_comb begin
    mag_a      = a_q[WIDTH-1] ? -a_q : a_q;
    mag_b      = b_q[WIDTH-1] ? -b_q : b_q;
    // Low half of acc holds the remaining multiplier bits; the carry lands in the top bit.
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    mul_step   = {mul_sum, acc_q[WIDTH-1:1]};
    prod_fixed = neg_res_q ? -acc_q : acc_q;
`ifdef MULDIV_DIV_EN
    // acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}
    div_rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff   = div_rem_sh - {1'b0, m_q};
    div_ok     = ~div_diff[WIDTH];
    div_step   = {(div_ok ? div_diff[WIDTH-1:0] : div_rem_sh[WIDTH-1:0]),
                  acc_q[WIDTH-2:0], div_ok};
    quo_fixed  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fixed  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif
  end

  // Sequencer: accept, prepare magnitudes, iterate WIDTH times, fix signs, publish
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    acc_d     = acc_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
`ifdef MULDIV_DIV_EN
    neg_rem_d = neg_rem_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && (op_mul ^ op_div)) begin
          a_d      = opa;
          b_d      = opb;
          is_div_d = op_div;
          dbz_d    = 1'b0;
          state_d  = S_PREP;
        end
      end
      S_PREP: begin
        neg_res_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        cnt_d     = CW'(WIDTH);
        acc_d     = '0;
        if (is_div_q) begin
`ifdef MULDIV_DIV_EN
          neg_rem_d = a_q[WIDTH-1];
          if (b_q == '0) begin
            hi_d    = a_q;
            lo_d    = '1;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, mag_a};
            m_d     = mag_b;
            state_d = S_RUN;
          end
`else
          // Divider not built: a divide request completes immediately with zeros.
          hi_d    = '0;
          lo_d    = '0;
          state_d = S_DONE;
`endif
        end else begin
          acc_d   = {{WIDTH{1'b0}}, mag_b};
          m_d     = mag_a;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
`ifdef MULDIV_DIV_EN
        acc_d = is_div_q ? div_step : mul_step;
`else
        acc_d = mul_step;
`endif
        if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
          hi_d = rem_fixed;
          lo_d = quo_fixed;
        end else begin
          {hi_d, lo_d} = prod_fixed;
        end
`else
        {hi_d, lo_d} = prod_fixed;
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      acc_q     <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
`ifdef MULDIV_DIV_EN
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

endmodule
